// File: rtl/ls_data_gen.sv
// Pattern source for test-chip characterisation: drives a pattern bit to the chip
// and a copy delayed by the chip latency for the downstream error counter.
module ls_data_gen (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [1:0]  MODE,
  input  logic [3:0]  LAT,
  output logic        DIN_CHIP,
  output logic        DATA,
  output logic        CMP_VALID,
  output logic [15:0] BIT_CNT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [6:0] PRBS_SEED = 7'h7F;

  state_t      state;
  state_t      state_nxt;
  logic        start;
  logic        advance;
  logic        stop;

  logic [1:0]  mode_q;
  logic [3:0]  lat_q;
  logic [3:0]  fill_cnt;
  logic [6:0]  lfsr;
  logic        alt;
  logic [15:0] dly;
  logic [15:0] bit_cnt;

  function automatic logic [6:0] lfsr_step(input logic [6:0] l);
    return {l[5:0], l[6] ^ l[5]};
  endfunction

  function automatic logic pat_bit(input logic [1:0] m, input logic a, input logic [6:0] l);
    logic b;
    case (m)
      2'b00:   b = 1'b0;
      2'b01:   b = 1'b1;
      2'b10:   b = a;
      default: b = l[6];
    endcase
    return b;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    advance   = 1'b0;
    stop      = 1'b0;
    case (state)
      IDLE: begin
        if (EN) begin
          start     = 1'b1;
          state_nxt = (LAT == 4'd0) ? RUN : FILL;
        end
      end
      FILL: begin
        if (!EN) begin
          stop      = 1'b1;
          state_nxt = IDLE;
        end else begin
          advance = 1'b1;
          if (fill_cnt == 4'd0) state_nxt = RUN;
        end
      end
      RUN: begin
        if (!EN) begin
          stop      = 1'b1;
          state_nxt = IDLE;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // dly[0] is the bit currently on DIN_CHIP; dly[i] is what it was i cycles ago.
  // The generator registers (lfsr, alt) always hold the state for the NEXT bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q   <= 2'd0;
      lat_q    <= 4'd0;
      fill_cnt <= 4'd0;
      lfsr     <= PRBS_SEED;
      alt      <= 1'b0;
      dly      <= 16'd0;
      bit_cnt  <= 16'd0;
    end else begin
      if (start) begin
        mode_q   <= MODE;
        lat_q    <= LAT;
        fill_cnt <= LAT - 4'd1;
        lfsr     <= lfsr_step(PRBS_SEED);
        alt      <= 1'b1;
        dly      <= {dly[14:0], pat_bit(MODE, 1'b0, PRBS_SEED)};
        bit_cnt  <= 16'd0;
      end else if (advance) begin
        dly  <= {dly[14:0], pat_bit(mode_q, alt, lfsr)};
        lfsr <= lfsr_step(lfsr);
        alt  <= ~alt;
        if (state == FILL) fill_cnt <= fill_cnt - 4'd1;
      end else if (stop) begin
        dly  <= 16'd0;
        lfsr <= PRBS_SEED;
        alt  <= 1'b0;
      end
      if (state == RUN && bit_cnt != 16'hFFFF) bit_cnt <= bit_cnt + 16'd1;
    end
  end

  assign DIN_CHIP  = dly[0];
  assign DATA      = dly[lat_q];
  assign CMP_VALID = (state == RUN);
  assign BIT_CNT   = bit_cnt;

endmodule

// File: tb/tb_ls_data_gen.sv
// Directed bench for ls_data_gen: pattern, latency alignment, counting, abort and reset.
module tb_ls_data_gen;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic [1:0]  MODE;
  logic [3:0]  LAT;
  logic        DIN_CHIP;
  logic        DATA;
  logic        CMP_VALID;
  logic [15:0] BIT_CNT;

  int tests_run;
  int tests_failed;
  logic prbs_ref [0:299];

  ls_data_gen dut (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .LAT(LAT),
    .DIN_CHIP(DIN_CHIP), .DATA(DATA), .CMP_VALID(CMP_VALID), .BIT_CNT(BIT_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_run(input logic [1:0] m, input logic [3:0] l);
    MODE = m;
    LAT  = l;
    EN   = 1'b1;
    tick();
  endtask

  task automatic build_prbs();
    logic [6:0] l;
    l = 7'h7F;
    for (int i = 0; i < 300; i++) begin
      prbs_ref[i] = l[6];
      l = {l[5:0], l[6] ^ l[5]};
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b0; MODE = 2'b00; LAT = 4'd0;
    tick(); tick();
    tests_run++;
    if ({DIN_CHIP, DATA, CMP_VALID} !== 3'b000 || BIT_CNT !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: din/data/valid=%b%b%b cnt=%0d, want 000 cnt=0", DIN_CHIP, DATA, CMP_VALID, BIT_CNT);
    end
    EN = 1'b1; MODE = 2'b01;
    tick();
    tests_run++;
    if ({DIN_CHIP, CMP_VALID} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_priority: din/valid=%b%b, want 00", DIN_CHIP, CMP_VALID);
    end
    RST = 1'b0;
    tick();
    tests_run++;
    if ({DIN_CHIP, DATA, CMP_VALID} !== 3'b111 || BIT_CNT !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL start_after_reset: din/data/valid=%b%b%b cnt=%0d, want 111 cnt=0", DIN_CHIP, DATA, CMP_VALID, BIT_CNT);
    end
    EN = 1'b0;
    tick();
    tests_run++;
    if ({DIN_CHIP, DATA, CMP_VALID} !== 3'b000 || BIT_CNT !== 16'd1) begin
      tests_failed++;
      $display("[TB] FAIL stop_one_bit: din/data/valid=%b%b%b cnt=%0d, want 000 cnt=1", DIN_CHIP, DATA, CMP_VALID, BIT_CNT);
    end
    tick();
  endtask

  task automatic test_alt_lat3();
    logic        exp_din, exp_data, exp_valid;
    logic [15:0] exp_cnt;
    start_run(2'b10, 4'd3);
    for (int j = 0; j < 12; j++) begin
      exp_din   = j[0];
      exp_valid = (j >= 3);
      exp_data  = (j >= 3) ? 1'((j - 3) & 1) : 1'b0;
      exp_cnt   = (j >= 3) ? 16'(j - 3) : 16'd0;
      tests_run++;
      if (DIN_CHIP !== exp_din || DATA !== exp_data || CMP_VALID !== exp_valid || BIT_CNT !== exp_cnt) begin
        tests_failed++;
        $display("[TB] FAIL alt_lat3 j=%0d: din/data/valid=%b%b%b cnt=%0d, want %b%b%b cnt=%0d",
                 j, DIN_CHIP, DATA, CMP_VALID, BIT_CNT, exp_din, exp_data, exp_valid, exp_cnt);
      end
      if (j != 11) tick();
    end
    EN = 1'b0;
    tick();
    tests_run++;
    if ({DIN_CHIP, DATA, CMP_VALID} !== 3'b000 || BIT_CNT !== 16'd9) begin
      tests_failed++;
      $display("[TB] FAIL alt_lat3_stop: din/data/valid=%b%b%b cnt=%0d, want 000 cnt=9", DIN_CHIP, DATA, CMP_VALID, BIT_CNT);
    end
    tick();
  endtask

  task automatic test_prbs_lat0();
    logic       got [0:13];
    logic [6:0] head, next7;
    start_run(2'b11, 4'd0);
    for (int j = 0; j < 300; j++) begin
      if (j < 14) got[j] = DIN_CHIP;
      tests_run++;
      if (DIN_CHIP !== prbs_ref[j] || DATA !== prbs_ref[j] || CMP_VALID !== 1'b1 || BIT_CNT !== 16'(j)) begin
        tests_failed++;
        $display("[TB] FAIL prbs_lat0 j=%0d: din/data/valid=%b%b%b cnt=%0d, want %b%b1 cnt=%0d",
                 j, DIN_CHIP, DATA, CMP_VALID, BIT_CNT, prbs_ref[j], prbs_ref[j], j);
      end
      if (j != 299) tick();
    end
    head  = {got[0], got[1], got[2], got[3], got[4], got[5], got[6]};
    next7 = {got[7], got[8], got[9], got[10], got[11], got[12], got[13]};
    tests_run++;
    if (head !== 7'b1111111 || next7 !== 7'b0000001) begin
      tests_failed++;
      $display("[TB] FAIL prbs_head: bits0-6=%b bits7-13=%b, want 1111111 0000001", head, next7);
    end
    EN = 1'b0;
    tick();
    tests_run++;
    if (CMP_VALID !== 1'b0 || BIT_CNT !== 16'd300) begin
      tests_failed++;
      $display("[TB] FAIL prbs_count: valid=%b cnt=%0d, want 0 cnt=300", CMP_VALID, BIT_CNT);
    end
    tick();
  endtask

  task automatic test_saturate();
    start_run(2'b01, 4'd15);
    for (int j = 0; j <= 70000; j++) begin
      if (j == 14) begin
        tests_run++;
        if (CMP_VALID !== 1'b0 || DATA !== 1'b0 || DIN_CHIP !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL sat_fill_end: din/data/valid=%b%b%b, want 100", DIN_CHIP, DATA, CMP_VALID);
        end
      end
      if (j == 15) begin
        tests_run++;
        if (CMP_VALID !== 1'b1 || DATA !== 1'b1 || BIT_CNT !== 16'd0) begin
          tests_failed++;
          $display("[TB] FAIL sat_valid_rise: data/valid=%b%b cnt=%0d, want 11 cnt=0", DATA, CMP_VALID, BIT_CNT);
        end
      end
      if (j == 1000 || j == 65549 || j == 65550 || j == 70000) begin
        tests_run++;
        if (BIT_CNT !== ((j >= 65550) ? 16'hFFFF : 16'(j - 15))) begin
          tests_failed++;
          $display("[TB] FAIL sat_count j=%0d: cnt=%0d, want %0d", j, BIT_CNT, (j >= 65550) ? 65535 : j - 15);
        end
      end
      if (j != 70000) tick();
    end
    EN = 1'b0;
    tick();
    tests_run++;
    if (CMP_VALID !== 1'b0 || BIT_CNT !== 16'hFFFF) begin
      tests_failed++;
      $display("[TB] FAIL sat_stop: valid=%b cnt=%0d, want 0 cnt=65535", CMP_VALID, BIT_CNT);
    end
    tick();
  endtask

  task automatic test_fill_abort();
    start_run(2'b11, 4'd8);
    for (int j = 0; j < 4; j++) begin
      tests_run++;
      if (CMP_VALID !== 1'b0 || DIN_CHIP !== prbs_ref[j] || DATA !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL fill_abort_fill j=%0d: din/data/valid=%b%b%b, want %b00", j, DIN_CHIP, DATA, CMP_VALID, prbs_ref[j]);
      end
      tick();
    end
    EN = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      tests_run++;
      if ({DIN_CHIP, DATA, CMP_VALID} !== 3'b000 || BIT_CNT !== 16'd0) begin
        tests_failed++;
        $display("[TB] FAIL fill_abort_idle j=%0d: din/data/valid=%b%b%b cnt=%0d, want 000 cnt=0",
                 j, DIN_CHIP, DATA, CMP_VALID, BIT_CNT);
      end
    end
  endtask

  task automatic test_rst_midrun();
    start_run(2'b11, 4'd0);
    for (int j = 0; j < 50; j++) begin
      tests_run++;
      if (DIN_CHIP !== prbs_ref[j]) begin
        tests_failed++;
        $display("[TB] FAIL rst_midrun_pre j=%0d: din=%b, want %b", j, DIN_CHIP, prbs_ref[j]);
      end
      tick();
    end
    tests_run++;
    if (BIT_CNT !== 16'd50) begin
      tests_failed++;
      $display("[TB] FAIL rst_midrun_cnt: cnt=%0d, want 50", BIT_CNT);
    end
    RST = 1'b1;
    tick();
    tests_run++;
    if ({DIN_CHIP, DATA, CMP_VALID} !== 3'b000 || BIT_CNT !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL rst_midrun_clear: din/data/valid=%b%b%b cnt=%0d, want 000 cnt=0", DIN_CHIP, DATA, CMP_VALID, BIT_CNT);
    end
    RST = 1'b0;
    tick();
    for (int j = 0; j < 20; j++) begin
      tests_run++;
      if (DIN_CHIP !== prbs_ref[j] || DATA !== prbs_ref[j] || CMP_VALID !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL rst_midrun_restart j=%0d: din/data/valid=%b%b%b, want %b%b1",
                 j, DIN_CHIP, DATA, CMP_VALID, prbs_ref[j], prbs_ref[j]);
      end
      tick();
    end
    EN = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_mode_lat_change();
    logic exp_data;
    start_run(2'b10, 4'd2);
    for (int j = 0; j < 16; j++) begin
      if (j == 4) begin
        MODE = 2'b01;
        LAT  = 4'd0;
      end
      exp_data = (j >= 2) ? 1'((j - 2) & 1) : 1'b0;
      tests_run++;
      if (DIN_CHIP !== j[0] || DATA !== exp_data || CMP_VALID !== (j >= 2)) begin
        tests_failed++;
        $display("[TB] FAIL mode_lat_change j=%0d: din/data/valid=%b%b%b, want %b%b%b",
                 j, DIN_CHIP, DATA, CMP_VALID, j[0], exp_data, (j >= 2));
      end
      if (j != 15) tick();
    end
    EN = 1'b0;
    tick();
    tests_run++;
    if (BIT_CNT !== 16'd14) begin
      tests_failed++;
      $display("[TB] FAIL mode_lat_change_cnt: cnt=%0d, want 14", BIT_CNT);
    end
    tick();
    EN = 1'b1;
    tick();
    tests_run++;
    if ({DIN_CHIP, DATA, CMP_VALID} !== 3'b111) begin
      tests_failed++;
      $display("[TB] FAIL mode_lat_next_run: din/data/valid=%b%b%b, want 111", DIN_CHIP, DATA, CMP_VALID);
    end
    EN = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    RST  = 1'b1;
    EN   = 1'b0;
    MODE = 2'b00;
    LAT  = 4'd0;
    build_prbs();
    test_reset();
    test_alt_lat3();
    test_prbs_lat0();
    test_fill_abort();
    test_rst_midrun();
    test_mode_lat_change();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
